// File: rtl/mod_updown_counter.sv
// Parametrised modulo up/down counter with clear, load, enable and a registered terminal-count pulse.
// Define MOD_COUNTER_OVF_STICKY_EN to build the sticky bound-hit flag; otherwise ovf_sticky is tied low.
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 10,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_zero,
  output logic             at_max,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
    $error("mod_updown_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_tc_nxt;
  logic             w_at_zero;
  logic             w_at_max;

  assign w_at_zero      = (r_count == '0);
  assign w_at_max       = (r_count == MAX_VAL);
  // Out-of-range loads clamp to the top state rather than wrapping.
  assign w_load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    if (clear) begin
      w_count_nxt = '0;
    end else if (load) begin
      w_count_nxt = w_load_clamped;
    end else if (en) begin
      if (up_dn) begin
        if (w_at_max) begin
          w_tc_nxt    = 1'b1;
          w_count_nxt = (SATURATE != 0) ? r_count : '0;
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
          w_tc_nxt    = 1'b1;
          w_count_nxt = (SATURATE != 0) ? r_count : MAX_VAL;
        end else begin
          w_count_nxt = r_count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

`ifdef MOD_COUNTER_OVF_STICKY_EN
  logic r_ovf;

  // Only clear or reset drop the flag; load leaves it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_ovf <= 1'b0;
    end else if (w_tc_nxt) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf_sticky = r_ovf;
`else
  assign ovf_sticky = 1'b0;
`endif

  assign count   = r_count;
  assign tc      = r_tc;
  assign at_zero = w_at_zero;
  assign at_max  = w_at_max;

endmodule
